// File: rtl/conv_sched_pkg.sv
// Shared definitions for the 3x3 convolution sequencer:
// FSM encoding, tap count, register map and address helper.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WT,
        S_RD,
        S_WR,
        S_FIN
    } state_t;

    localparam int KTAPS = 9;

    localparam logic [7:0] CONV_CTRL_ADDR    = 8'h00;
    localparam logic [7:0] CONV_STATUS_ADDR  = 8'h04;
    localparam logic [7:0] CONV_DIM_ADDR     = 8'h08;
    localparam logic [7:0] CONV_IFM_OFS_ADDR = 8'h0C;
    localparam logic [7:0] CONV_WT_OFS_ADDR  = 8'h10;
    localparam logic [7:0] CONV_OFM_OFS_ADDR = 8'h14;

    function automatic logic [31:0] word_addr(
        input logic [31:0] base,
        input logic [31:0] idx
    );
        return base + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/conv_tap_addr.sv
// Tap geometry for one 3x3 window position: padding test and
// input-map byte address, all index math in 32-bit wrap.
module conv_tap_addr
    import conv_sched_pkg::*;
(
    input  logic [31:0] i_r,
    input  logic [31:0] i_c,
    input  logic [3:0]  i_t,
    input  logic [31:0] i_n,
    input  logic [31:0] i_ofs,
    output logic        o_in_bound,
    output logic [31:0] o_addr
);

    logic [1:0]  w_rs;
    logic [1:0]  w_cs;
    logic        w_tv;
    logic        w_row_ok;
    logic        w_col_ok;
    logic [31:0] w_rr;
    logic [31:0] w_cc;
    logic [31:0] w_idx;

    // row/col selector: 0 -> -1, 1 -> 0, 2 -> +1
    always_comb begin
        w_tv = (i_t < 4'(KTAPS));
        w_rs = (i_t < 4'd3) ? 2'd0 :
               (i_t < 4'd6) ? 2'd1 : 2'd2;
        w_cs = 2'(i_t - 4'd3 * {2'b00, w_rs});
    end

    always_comb begin
        w_rr     = i_r;
        w_row_ok = 1'b1;
        if (w_rs == 2'd0) begin
            w_rr     = i_r - 32'd1;
            w_row_ok = (i_r != 32'd0);
        end else if (w_rs == 2'd2) begin
            w_rr     = i_r + 32'd1;
            w_row_ok = (i_r + 32'd1 < i_n);
        end
    end

    always_comb begin
        w_cc     = i_c;
        w_col_ok = 1'b1;
        if (w_cs == 2'd0) begin
            w_cc     = i_c - 32'd1;
            w_col_ok = (i_c != 32'd0);
        end else if (w_cs == 2'd2) begin
            w_cc     = i_c + 32'd1;
            w_col_ok = (i_c + 32'd1 < i_n);
        end
    end

    assign w_idx      = w_rr * i_n + w_cc;
    assign o_in_bound = w_tv & w_row_ok & w_col_ok;
    assign o_addr     = word_addr(i_ofs, w_idx);

endmodule

// File: rtl/conv_sched.sv
// 3x3 zero-padded convolution sequencer over a shared memory port.
// Optional CONV_RELU_EN clamps negative results to 0 on write-back.
module conv_sched
    import conv_sched_pkg::*;
#(
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [31:0]       fm_dim_i,
    input  logic [31:0]       ifm_offset_i,
    input  logic [31:0]       wt_offset_i,
    input  logic [31:0]       ofm_offset_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              idle_o,
    output logic              done_o
);

    localparam logic [DIM_W-1:0] ONE  = DIM_W'(1);
    localparam logic [3:0]       TEND = 4'(KTAPS);

    state_t           r_state;
    logic [DIM_W-1:0] r_n;
    logic [DIM_W-1:0] r_r;
    logic [DIM_W-1:0] r_c;
    logic [3:0]       r_t;
    logic [31:0]      r_ifm;
    logic [31:0]      r_wt;
    logic [31:0]      r_ofm;
    logic [31:0]      r_acc;
    logic [31:0]      r_wbuf [KTAPS];
    logic             r_pend;
    logic [3:0]       r_pend_t;
    logic             r_idle;
    logic             r_done;

    logic        w_tap_ok;
    logic [31:0] w_tap_addr;
    logic [31:0] w_pix_idx;
    logic [31:0] w_res;
    logic [31:0] w_prod;
    logic        w_req;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_gnt;
    logic        w_unused;

    conv_tap_addr u_tap (
        .i_r        (32'(r_r)),
        .i_c        (32'(r_c)),
        .i_t        (r_t),
        .i_n        (32'(r_n)),
        .i_ofs      (r_ifm),
        .o_in_bound (w_tap_ok),
        .o_addr     (w_tap_addr)
    );

    assign w_pix_idx = 32'(r_r) * 32'(r_n) + 32'(r_c);
    assign w_prod    = r_wbuf[r_pend_t] * mem_rdata_i;
    assign w_unused  = &{1'b0, fm_dim_i[31:DIM_W]};

`ifdef CONV_RELU_EN
    assign w_res = r_acc[31] ? 32'd0 : r_acc;
`else
    assign w_res = r_acc;
`endif

    // Request lines depend only on registered state, so they hold across stalls.
    always_comb begin
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_addr  = 32'd0;
        w_wdata = 32'd0;
        unique case (r_state)
            S_LD_WT: begin
                if (r_t < TEND) begin
                    w_req  = 1'b1;
                    w_addr = word_addr(r_wt, 32'(r_t));
                end
            end
            S_RD: begin
                if (w_tap_ok) begin
                    w_req  = 1'b1;
                    w_addr = w_tap_addr;
                end
            end
            S_WR: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = word_addr(r_ofm, w_pix_idx);
                w_wdata = w_res;
            end
            default: ;
        endcase
    end

    assign w_gnt       = w_req & mem_gnt_i;
    assign mem_req_o   = w_req;
    assign mem_we_o    = w_we;
    assign mem_addr_o  = w_addr[ADDR_W-1:0];
    assign mem_wdata_o = w_wdata;
    assign idle_o      = r_idle;
    assign done_o      = r_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_r      <= '0;
            r_c      <= '0;
            r_t      <= '0;
            r_ifm    <= '0;
            r_wt     <= '0;
            r_ofm    <= '0;
            r_acc    <= '0;
            r_pend   <= 1'b0;
            r_pend_t <= '0;
            r_idle   <= 1'b1;
            r_done   <= 1'b0;
            for (int i = 0; i < KTAPS; i++) r_wbuf[i] <= '0;
        end else begin
            r_pend <= 1'b0;
            // read data lands one cycle after its grant, still in the same state
            if (r_pend) begin
                if (r_state == S_LD_WT) r_wbuf[r_pend_t] <= mem_rdata_i;
                else                    r_acc <= r_acc + w_prod;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_n   <= fm_dim_i[DIM_W-1:0];
                        r_ifm <= ifm_offset_i;
                        r_wt  <= wt_offset_i;
                        r_ofm <= ofm_offset_i;
                        if (fm_dim_i[DIM_W-1:0] == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_done  <= 1'b0;
                            r_idle  <= 1'b0;
                            r_state <= S_LD_WT;
                            r_t     <= '0;
                            r_r     <= '0;
                            r_c     <= '0;
                            r_acc   <= '0;
                        end
                    end
                end
                S_LD_WT: begin
                    if (r_t == TEND) begin
                        r_state <= S_RD;
                        r_t     <= '0;
                    end else if (w_gnt) begin
                        r_pend   <= 1'b1;
                        r_pend_t <= r_t;
                        r_t      <= r_t + 4'd1;
                    end
                end
                S_RD: begin
                    if (r_t == TEND) begin
                        r_state <= S_WR;
                    end else if (!w_tap_ok) begin
                        r_t <= r_t + 4'd1;
                    end else if (w_gnt) begin
                        r_pend   <= 1'b1;
                        r_pend_t <= r_t;
                        r_t      <= r_t + 4'd1;
                    end
                end
                S_WR: begin
                    if (mem_gnt_i) begin
                        r_acc <= '0;
                        r_t   <= '0;
                        if (r_c == r_n - ONE) begin
                            r_c <= '0;
                            if (r_r == r_n - ONE) begin
                                r_state <= S_FIN;
                            end else begin
                                r_r     <= r_r + ONE;
                                r_state <= S_RD;
                            end
                        end else begin
                            r_c     <= r_c + ONE;
                            r_state <= S_RD;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_idle  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
